serial_adder: RTL
=================

Name: serial_adder

Overview:
- LSB-first bit-serial adder that adds two WIDTH-bit operands plus a carry-in, one bit per clock.
- Built around a single full-adder cell made of two half_adder instances, so one adder cell serves any operand width.
- Sits between an operand source (register file or loader) and the result consumer.
- Start/done handshake: operands are captured in parallel, and the result is presented in parallel with a one-cycle done pulse.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  operand A, captured on the accepting edge
b  input  WIDTH  operand B, captured on the accepting edge
cin  input  1  carry-in, captured on the accepting edge
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  result register (sum[WIDTH-1:0] of a+b+cin)
cout  output  1  final carry-out

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0), applied at any time including mid-RUN:
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - internal A/B shift registers, carry flop and bit counter all cleared.
  - on deassertion the block waits for a fresh start; the aborted operation is lost.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> load A<=a, B<=b, carry<=cin, cnt<=0; go to RUN.
  - otherwise stay in IDLE.
- RUN, each cycle:
  - s = A[0]^B[0]^carry, c = majority(A[0],B[0],carry), both from the full-adder sub-module.
  - sum <= {s, sum[WIDTH-1:1]}; A,B shift right by one; carry<=c; cnt<=cnt+1.
  - when cnt==WIDTH-1: cout<=c; go to DONE.
  - start is ignored in RUN.
- DONE: lasts exactly one cycle.
  - done=1, busy=0.
  - start=1 -> load new operands and go to RUN (back-to-back, no idle bubble).
  - otherwise go to IDLE.
- Latency: the accepting edge is T0. Bits are processed on edges T1..TWIDTH; done is high in the cycle after edge TWIDTH.
  - Throughput: one add per WIDTH+1 cycles.
- sum shifts during RUN and is valid only while done=1 or after it.
  - sum and cout hold their value in IDLE until the next operation's first RUN edge.
- busy = (state==RUN); done = (state==DONE). Both are combinational decodes of registered state.
- Arithmetic: unsigned modulo 2^WIDTH; cout is bit WIDTH of a+b+cin.
  - Wrap-around example: a=all-ones, b=0, cin=1 -> sum=0, cout=1.
- Counter width: $clog2(WIDTH).

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - adds output port ovf (1 bit, reset 0), the two's-complement overflow flag.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, registered on the last RUN edge together with cout.
  - valid with done; held like sum.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package serial_adder_pkg holds:
  - state typedef/encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 decodes to IDLE.
  - the WIDTH legality bounds, MIN_WIDTH=2 and MAX_WIDTH=32.
- One sub-module: full_adder (a, b, cin, sum, carry), combinational, built from two half_adder instances plus an OR of the two carries.
  - serial_adder instantiates exactly one full_adder.

Test Plan:
- WIDTH=8, a=8'h35, b=8'h4A, cin=0, start pulse -> busy high 8 cycles; done pulse on cycle 9; sum=8'h7F, cout=0.
- a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1 (full carry ripple across all bits); with SERIAL_ADDER_OVF_EN, ovf=0.
- a=8'h7F, b=8'h01, cin=0 with SERIAL_ADDER_OVF_EN -> sum=8'h80, cout=0, ovf=1. Then a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
- start held high continuously with new operands presented at each done -> operations back-to-back every 9 cycles; no idle cycle; each result matches its operands.
- start pulsed again during RUN (cycle 3) with different a/b -> ignored; result reflects the first operands only.
- rst_n dropped asynchronously mid-RUN (cycle 4, between clock edges) -> busy, done, sum, cout go 0 immediately. After release there is no done until a new start; a subsequent add (8'h10+8'h20) gives 8'h30.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
// The optional overflow flag is enabled by defining SERIAL_ADDER_OVF_EN when building serial_adder.
package serial_adder_pkg;

    // Legal range for the serial_adder WIDTH parameter.
    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    // 2'd3 is unused and is treated as IDLE by the controller.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// Combinational one-bit full adder built from two half adders.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic partSum;
    logic partCarry;
    logic finalCarry;

    half_adder u_haLow (
        .a     (a),
        .b     (b),
        .sum   (partSum),
        .carry (partCarry)
    );

    half_adder u_haHigh (
        .a     (partSum),
        .b     (cin),
        .sum   (sum),
        .carry (finalCarry)
    );

    // The two half-adder carries can never both be set, so OR is the majority.
    assign carry = partCarry | finalCarry;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder; two of these plus an OR gate form the full-adder cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder: one full-adder cell, one result per WIDTH+1 cycles.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_badWidth
        $error("serial_adder: WIDTH must lie between MIN_WIDTH and MAX_WIDTH");
    end

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] opA_q,    opA_d;
    logic [WIDTH-1:0] opB_q,    opB_d;
    logic             carry_q,  carry_d;
    logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q,    ovf_d;
`endif

    logic faSum;
    logic faCarry;

    full_adder u_fullAdder (
        .a     (opA_q[0]),
        .b     (opB_q[0]),
        .cin   (carry_q),
        .sum   (faSum),
        .carry (faCarry)
    );

    // Next-state logic; the operand load is shared by IDLE and DONE so a
    // start seen in DONE begins the next add with no idle bubble.
    always_comb begin
        state_d  = state_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        carry_d  = carry_q;
        bitCnt_d = bitCnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            RUN: begin
                sum_d    = {faSum, sum_q[WIDTH-1:1]};
                opA_d    = opA_q >> 1;
                opB_d    = opB_q >> 1;
                carry_d  = faCarry;
                bitCnt_d = bitCnt_q + 1'b1;
                if (bitCnt_q == LAST_BIT) begin
                    cout_d  = faCarry;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on this final edge.
                    ovf_d   = carry_q ^ faCarry;
`endif
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                if (start) begin
                    opA_d    = a;
                    opB_d    = b;
                    carry_d  = cin;
                    bitCnt_d = '0;
                    state_d  = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            opA_q    <= '0;
            opB_q    <= '0;
            carry_q  <= 1'b0;
            bitCnt_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            carry_q  <= carry_d;
            bitCnt_q <= bitCnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
